neuron_mac: RTL
===============

NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 The block SHALL have the following parameters, one per line:
- DATA_WIDTH, 16, signed fixed-point word width.
- FRAC_BITS, 8, fractional bits of every data, weight, bias and output word.
- NUM_INPUTS, 16, input vector length.
- LANES, 4, multipliers used per cycle; NUM_INPUTS % LANES != 0 is an elaboration error.
- ACTIVATION, "relu", one of "relu", "identity", "leaky"; any other value is an elaboration error.

REQ-002 The block SHALL have the following ports, one per line:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  input vector valid.
- in_ready  output  1  block can accept a vector.
- inputs  input  NUM_INPUTS x DATA_WIDTH signed  input vector.
- wr_en  input  1  parameter write strobe.
- wr_addr  input  $clog2(NUM_INPUTS+1)  write target.
- wr_data  input  DATA_WIDTH signed  write value.
- out  output  DATA_WIDTH signed  activated result.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.

Function
REQ-003 The FSM SHALL have four states: IDLE, MAC, ACT and DONE.
REQ-004 in_ready SHALL be 1 only in IDLE; the input handshake is in_valid && in_ready at a rising edge.
REQ-005 On the handshake edge the block SHALL latch all inputs, clear the accumulator, zero the beat counter and go to MAC.
REQ-006 MAC SHALL last exactly NUM_INPUTS/LANES cycles; at each edge it SHALL add LANES products inputs[k]*weights[k] to the accumulator, where k = beat*LANES + lane, then increment the beat counter.
REQ-007 After the last beat the FSM SHALL go to ACT.
REQ-008 The accumulator SHALL be signed with width 2*DATA_WIDTH + $clog2(NUM_INPUTS) + 1 and SHALL never overflow.
REQ-009 In ACT the block SHALL compute s = (acc + (bias <<< FRAC_BITS)) >>> FRAC_BITS using an arithmetic shift.
REQ-010 In ACT the block SHALL then apply the activation to s: relu gives max(s,0); identity gives s; leaky gives s when s >= 0, else s >>> 3.
REQ-011 The ACT result SHALL be saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], registered into out at the ACT edge, and the FSM SHALL go to DONE.
REQ-012 out_valid SHALL be 1 only in DONE; latency from the handshake edge to out_valid rising SHALL be NUM_INPUTS/LANES + 1 cycles (5 at defaults).
REQ-013 In DONE, out SHALL hold stable while out_ready=0; on out_valid && out_ready the FSM SHALL return to IDLE, and out SHALL keep its value until the next ACT.
REQ-014 in_valid outside IDLE SHALL be ignored; no vector SHALL be queued.
REQ-015 A write with wr_en=1 in IDLE SHALL update weights[wr_addr] when wr_addr < NUM_INPUTS, update bias when wr_addr == NUM_INPUTS, and be ignored for larger addresses.
REQ-016 wr_en outside IDLE SHALL be ignored, so parameters are stable during a computation.
REQ-017 A write and an input handshake at the same edge SHALL both take effect, and that computation SHALL use the newly written value.

Reset
REQ-018 While reset=1, asynchronously: state SHALL be IDLE, and out, out_valid, accumulator, beat counter, all weights and bias SHALL be 0.
REQ-019 in_ready SHALL read 1 in the first cycle after reset deasserts.
REQ-020 Reset asserted in MAC, ACT or DONE SHALL abort the computation, and no out_valid SHALL follow for it.

Verification
REQ-021 Defaults; all weights 256, bias 0, inputs all 256 -> out=4096, out_valid 5 cycles after the handshake.
REQ-022 Bias 512, inputs all 0 -> out=512; bias 0 -> out=0.
REQ-023 Weights 256, inputs all -256: relu -> out=0; leaky -> out=-512; identity -> out=-4096.
REQ-024 Weights 32767, inputs 32767 -> out=32767; inputs -32768 with identity -> out=-32768 (saturation).
REQ-025 out_ready=0 for 10 cycles in DONE -> out and out_valid stable; in_ready=0; in_valid pulses and wr_en pulses ignored (weight readback via the next result unchanged).
REQ-026 Reset asserted on beat 2 of MAC -> out=0, out_valid=0, in_ready=1 after deassert; weights read 0 (next result with bias 0 is 0).

Source files
------------

// File: rtl/neuron_mac.sv
`default_nettype none
// ============================================================================
//  Module   : neuron_mac
//  Purpose  : Single artificial neuron. Accepts an input vector, multiplies it
//             against a stored weight vector LANES products per cycle, adds a
//             stored bias, applies an activation and saturates the result to
//             the data word width.
//  Ports    : clock, reset       - rising-edge clock, async active-high reset
//             in_valid/in_ready  - input vector handshake (ready only in IDLE)
//             inputs             - NUM_INPUTS signed fixed-point words
//             wr_en/addr/data    - weight (addr < NUM_INPUTS) or bias
//                                  (addr == NUM_INPUTS) write, IDLE only
//             out/out_valid/out_ready - activated result handshake
//  Revision : 1.0 - initial release
// ============================================================================
module neuron_mac #(
    parameter int    DATA_WIDTH = 16,
    parameter int    FRAC_BITS  = 8,
    parameter int    NUM_INPUTS = 16,
    parameter int    LANES      = 4,
    parameter string ACTIVATION = "relu"
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] inputs,
    input  logic                                  wr_en,
    input  logic [$clog2(NUM_INPUTS+1)-1:0]       wr_addr,
    input  logic signed [DATA_WIDTH-1:0]          wr_data,
    output logic signed [DATA_WIDTH-1:0]          out,
    output logic                                  out_valid,
    input  logic                                  out_ready
);

    localparam int NUM_BEATS = NUM_INPUTS / LANES;
    localparam int ADDR_W    = $clog2(NUM_INPUTS + 1);
    localparam int IDX_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    // Wide enough for NUM_INPUTS full-scale products plus the shifted bias.
    localparam int ACC_W     = 2 * DATA_WIDTH + $clog2(NUM_INPUTS) + 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);
    localparam logic [ADDR_W-1:0] BIAS_ADDR = ADDR_W'(NUM_INPUTS);

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_ACT  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (NUM_INPUTS % LANES != 0) begin : g_bad_lanes
        $error("neuron_mac: NUM_INPUTS must be a multiple of LANES");
    end

    logic [1:0]                   state;
    logic [1:0]                   next_state;
    logic                         accept;
    logic                         param_wr;
    logic [BEAT_W-1:0]            beat;
    logic signed [ACC_W-1:0]      acc;
    logic signed [ACC_W-1:0]      beat_sum;
    logic signed [DATA_WIDTH-1:0] data_q  [NUM_INPUTS];
    logic signed [DATA_WIDTH-1:0] weights [NUM_INPUTS];
    logic signed [DATA_WIDTH-1:0] bias;
    logic signed [2*DATA_WIDTH-1:0] prod  [LANES];
    logic signed [ACC_W-1:0]      biased;
    logic signed [ACC_W-1:0]      scaled;
    logic signed [ACC_W-1:0]      activated;
    logic signed [DATA_WIDTH-1:0] out_next;

    assign accept   = in_valid && in_ready;
    // Parameters only change in IDLE so a running computation sees a stable set.
    assign param_wr = wr_en && (state == S_IDLE);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (in_valid)          next_state = S_MAC;
            S_MAC:   if (beat == LAST_BEAT) next_state = S_ACT;
            S_ACT:                          next_state = S_DONE;
            S_DONE:  if (out_ready)         next_state = S_IDLE;
            default:                        next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
    end

    // ------------------------------------------------------------------
    // Lane multipliers: lane l of beat b uses element b*LANES + l
    // ------------------------------------------------------------------
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [IDX_W-1:0] idx;
        assign idx     = IDX_W'(int'(beat) * LANES + l);
        assign prod[l] = data_q[idx] * weights[idx];
    end

    always_comb begin
        beat_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            beat_sum = beat_sum + ACC_W'(prod[l]);
        end
    end

    // ------------------------------------------------------------------
    // Bias, rescale and activation
    // ------------------------------------------------------------------
    assign biased = acc + (ACC_W'(bias) <<< FRAC_BITS);
    assign scaled = biased >>> FRAC_BITS;

    if (ACTIVATION == "relu") begin : g_act_relu
        assign activated = scaled[ACC_W-1] ? '0 : scaled;
    end else if (ACTIVATION == "identity") begin : g_act_identity
        assign activated = scaled;
    end else if (ACTIVATION == "leaky") begin : g_act_leaky
        assign activated = scaled[ACC_W-1] ? (scaled >>> 3) : scaled;
    end else begin : g_act_bad
        assign activated = scaled;
        $error("neuron_mac: ACTIVATION must be relu, identity or leaky");
    end

    always_comb begin
        out_next = activated[DATA_WIDTH-1:0];
        if (activated > SAT_MAX) begin
            out_next = SAT_MAX[DATA_WIDTH-1:0];
        end else if (activated < SAT_MIN) begin
            out_next = SAT_MIN[DATA_WIDTH-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Input vector capture (contents are don't-care until the handshake)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (accept) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                data_q[i] <= $signed(inputs[i]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Accumulator, beat counter and result register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc  <= '0;
            beat <= '0;
            out  <= '0;
        end else begin
            if (accept) begin
                acc  <= '0;
                beat <= '0;
            end else if (state == S_MAC) begin
                acc  <= acc + beat_sum;
                beat <= beat + BEAT_W'(1);
            end
            if (state == S_ACT) begin
                out <= out_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Weight and bias storage
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                weights[i] <= '0;
            end
            bias <= '0;
        end else if (param_wr) begin
            if (wr_addr < BIAS_ADDR) begin
                weights[wr_addr[IDX_W-1:0]] <= wr_data;
            end else if (wr_addr == BIAS_ADDR) begin
                bias <= wr_data;
            end
        end
    end

endmodule
`default_nettype wire
